// File: rtl/conv_tree_ser_arbiter_if.sv
// Requester/serializer bus for conv_tree_ser_arbiter.
//   REQ_VALID   per-requester word valid            (master -> slave)
//   REQ_DATA    packed requester words, i at [i*W]  (master -> slave)
//   REQ_READY   one-hot grant/accept                (slave -> master)
//   PAR_IN      word held for the serializer        (slave -> master)
//   SER_ACTIVE  high while a word is held           (slave -> master)
//   FRAME_START one-cycle pulse at frame start      (slave -> master)
//   GRANT_ID    owner of the current/last frame     (slave -> master)
interface conv_tree_ser_arbiter_if #(
  parameter int INPUTS_NUM = 4,
  parameter int NUM_REQ    = 4
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            REQ_VALID;
  logic [NUM_REQ*INPUTS_NUM-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]            REQ_READY;
  logic [INPUTS_NUM-1:0]         PAR_IN;
  logic                          SER_ACTIVE;
  logic                          FRAME_START;
  logic [IDW-1:0]                GRANT_ID;

  modport master (
    output REQ_VALID, REQ_DATA,
    input  REQ_READY, PAR_IN, SER_ACTIVE, FRAME_START, GRANT_ID
  );

  modport slave (
    input  REQ_VALID, REQ_DATA,
    output REQ_READY, PAR_IN, SER_ACTIVE, FRAME_START, GRANT_ID
  );
endinterface

// File: rtl/conv_tree_ser_arbiter.sv
// Round-robin arbiter feeding a parallel-to-serial converter. A granted
// word is held on PAR_IN for INPUTS_NUM/2 cycles, followed by GAP_CYCLES
// all-zero cycles, before the next requester can be accepted.
// Ports:
//   CLK    rising-edge clock
//   RESET  synchronous active-high reset
//   bus    conv_tree_ser_arbiter_if.slave (requests in, frame out)
module conv_tree_ser_arbiter #(
  parameter int INPUTS_NUM = 4,
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                    CLK,
  input  logic                    RESET,
  conv_tree_ser_arbiter_if.slave  bus
);
  localparam int SER_CYCLES = INPUTS_NUM / 2;
  localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAXC       = (SER_CYCLES > GAP_CYCLES) ? SER_CYCLES : GAP_CYCLES;
  localparam int CW         = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                state_q, state_n;
  logic [CW-1:0]         cnt_q, cnt_n;
  logic [IDW-1:0]        ptr_q, ptr_n;
  logic [INPUTS_NUM-1:0] par_q, par_n;
  logic                  act_q, act_n;
  logic                  fs_q, fs_n;
  logic [IDW-1:0]        gid_q, gid_n;

  logic                  win_found;
  logic [IDW-1:0]        win_id;
  logic [INPUTS_NUM-1:0] win_word;
  logic                  hs;
  logic [2*NUM_REQ-1:0]  vv;
  int unsigned           sum;

  // Doubling the valid vector and shifting by PTR turns the wrapping
  // search into a plain lowest-set-bit scan over constant indices.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_word  = '0;
    sum       = 0;
    vv        = {bus.REQ_VALID, bus.REQ_VALID} >> ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_found && vv[i]) begin
        win_found = 1'b1;
        sum       = 32'(ptr_q) + i;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        win_id    = IDW'(sum);
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (IDW'(j) == win_id) win_word = bus.REQ_DATA[j*INPUTS_NUM +: INPUTS_NUM];
    end
  end

  assign hs            = (state_q == IDLE) && !RESET && win_found;
  assign bus.REQ_READY = hs ? (NUM_REQ'(1) << win_id) : '0;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    ptr_n   = ptr_q;
    par_n   = par_q;
    act_n   = act_q;
    fs_n    = 1'b0;
    gid_n   = gid_q;
    unique case (state_q)
      IDLE: begin
        par_n = '0;
        act_n = 1'b0;
        if (hs) begin
          par_n   = win_word;
          gid_n   = win_id;
          ptr_n   = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
          cnt_n   = CW'(SER_CYCLES - 1);
          act_n   = 1'b1;
          fs_n    = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        if (cnt_q == '0) begin
          par_n = '0;
          act_n = 1'b0;
          if (GAP_CYCLES > 0) begin
            cnt_n   = CW'(GAP_CYCLES - 1);
            state_n = GAP;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      GAP: begin
        par_n = '0;
        act_n = 1'b0;
        if (cnt_q == '0) state_n = IDLE;
        else             cnt_n   = cnt_q - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      par_q   <= '0;
      act_q   <= 1'b0;
      fs_q    <= 1'b0;
      gid_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      ptr_q   <= ptr_n;
      par_q   <= par_n;
      act_q   <= act_n;
      fs_q    <= fs_n;
      gid_q   <= gid_n;
    end
  end

  assign bus.PAR_IN      = par_q;
  assign bus.SER_ACTIVE  = act_q;
  assign bus.FRAME_START = fs_q;
  assign bus.GRANT_ID    = gid_q;
endmodule

// File: tb/tb_conv_tree_ser_arbiter.sv
module tb_conv_tree_ser_arbiter;
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  conv_tree_ser_arbiter_if #(.INPUTS_NUM(4), .NUM_REQ(4)) bus_a ();
  conv_tree_ser_arbiter_if #(.INPUTS_NUM(8), .NUM_REQ(4)) bus_b ();

  conv_tree_ser_arbiter #(.INPUTS_NUM(4), .NUM_REQ(4), .GAP_CYCLES(2)) dut_a (
    .CLK(CLK), .RESET(RESET), .bus(bus_a));
  conv_tree_ser_arbiter #(.INPUTS_NUM(8), .NUM_REQ(4), .GAP_CYCLES(0)) dut_b (
    .CLK(CLK), .RESET(RESET), .bus(bus_b));

  typedef struct {
    logic [31:0] gid;
    logic [31:0] word;
  } exp_t;

  exp_t        sb_a[$];
  exp_t        sb_b[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cycle  = 0;
  int unsigned last_fs[2];

  always @(posedge CLK) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int sel, input logic [31:0] gid, input logic [31:0] word);
    exp_t e;
    e.gid  = gid;
    e.word = word;
    if (sel == 0) sb_a.push_back(e);
    else          sb_b.push_back(e);
  endtask

  task automatic snap(input int sel, output logic fs, output logic act,
                      output logic [31:0] par, output logic [31:0] gid, output logic [31:0] rdy);
    if (sel == 0) begin
      fs = bus_a.FRAME_START; act = bus_a.SER_ACTIVE; par = 32'(bus_a.PAR_IN);
      gid = 32'(bus_a.GRANT_ID); rdy = 32'(bus_a.REQ_READY);
    end else begin
      fs = bus_b.FRAME_START; act = bus_b.SER_ACTIVE; par = 32'(bus_b.PAR_IN);
      gid = 32'(bus_b.GRANT_ID); rdy = 32'(bus_b.REQ_READY);
    end
  endtask

  // Waits (bounded) for FRAME_START, pops the expected frame and checks
  // the held word and the trailing gap. Ends on the last negedge of the frame.
  task automatic check_frame(input int sel, input int ser, input int gap, input int period);
    logic        fs, act;
    logic [31:0] par, gid, rdy;
    exp_t        e;
    bit          seen;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      snap(sel, fs, act, par, gid, rdy);
      if (fs === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    check("frame_seen", 32'(seen), 32'd1);
    if (!seen) return;
    if (sel == 0) begin
      check("sb_a_pending", 32'(sb_a.size() != 0), 32'd1);
      if (sb_a.size() == 0) return;
      e = sb_a.pop_front();
    end else begin
      check("sb_b_pending", 32'(sb_b.size() != 0), 32'd1);
      if (sb_b.size() == 0) return;
      e = sb_b.pop_front();
    end
    if (period > 0) check("frame_period", cycle - last_fs[sel], 32'(period));
    last_fs[sel] = cycle;
    check("frame_gid", gid, e.gid);
    check("frame_word", par, e.word);
    check("frame_active", 32'(act), 32'd1);
    for (int k = 1; k < ser; k++) begin
      @(negedge CLK);
      snap(sel, fs, act, par, gid, rdy);
      check("hold_word", par, e.word);
      check("hold_active", 32'(act), 32'd1);
      check("hold_fs_low", 32'(fs), 32'd0);
    end
    for (int k = 0; k < gap; k++) begin
      @(negedge CLK);
      snap(sel, fs, act, par, gid, rdy);
      check("gap_word", par, 32'd0);
      check("gap_active", 32'(act), 32'd0);
      check("gap_ready", rdy, 32'd0);
    end
  endtask

  initial begin
    logic        fs, act;
    logic [31:0] par, gid, rdy;
    exp_t        e;

    // Reset with all requesters asserting valid.
    RESET = 1'b1;
    bus_a.REQ_VALID = 4'b1111;
    bus_a.REQ_DATA  = {4'h3, 4'hC, 4'h5, 4'hA};
    bus_b.REQ_VALID = 4'b1111;
    bus_b.REQ_DATA  = '0;
    @(negedge CLK);
    snap(0, fs, act, par, gid, rdy);
    check("rst_ready", rdy, 32'd0);
    check("rst_par", par, 32'd0);
    check("rst_active", 32'(act), 32'd0);
    check("rst_fs", 32'(fs), 32'd0);
    check("rst_gid", gid, 32'd0);
    check("rst_b_par", 32'(bus_b.PAR_IN), 32'd0);
    @(negedge CLK);
    check("rst_ready2", 32'(bus_a.REQ_READY), 32'd0);
    check("rst_b_ready2", 32'(bus_b.REQ_READY), 32'd0);

    // All requesters held valid: rotation 0,1,2,3,0 every 5 cycles.
    RESET = 1'b0;
    bus_b.REQ_VALID = '0;
    #1;
    check("rr_first_ready", 32'(bus_a.REQ_READY), 32'b0001);
    push(0, 0, 32'hA); push(0, 1, 32'h5); push(0, 2, 32'hC);
    push(0, 3, 32'h3); push(0, 0, 32'hA);
    check_frame(0, 2, 2, 0);
    for (int f = 0; f < 4; f++) check_frame(0, 2, 2, 5);
    bus_a.REQ_VALID = '0;
    @(negedge CLK);
    check("rr_idle_ready", 32'(bus_a.REQ_READY), 32'd0);
    check("rr_idle_gid", 32'(bus_a.GRANT_ID), 32'd0);

    // Single requester 1.
    bus_a.REQ_DATA[7:4] = 4'hB;
    bus_a.REQ_VALID = 4'b0010;
    #1;
    check("single_ready", 32'(bus_a.REQ_READY), 32'b0010);
    push(0, 1, 32'hB);
    @(negedge CLK);
    bus_a.REQ_VALID = '0;
    check_frame(0, 2, 2, 0);
    @(negedge CLK);
    check("single_idle_par", 32'(bus_a.PAR_IN), 32'd0);
    check("single_idle_gid", 32'(bus_a.GRANT_ID), 32'd1);
    check("single_idle_ready", 32'(bus_a.REQ_READY), 32'd0);

    // Valid changes during a frame are ignored (pointer now 2 -> wins 0).
    bus_a.REQ_VALID = 4'b0001;
    #1;
    check("busy_ready0", 32'(bus_a.REQ_READY), 32'b0001);
    push(0, 0, 32'hA);
    @(negedge CLK);
    snap(0, fs, act, par, gid, rdy);
    e = sb_a.pop_front();
    check("busy_fs", 32'(fs), 32'd1);
    check("busy_gid", gid, e.gid);
    check("busy_word", par, e.word);
    bus_a.REQ_VALID = 4'b0100;
    #1;
    check("busy_ready_send1", 32'(bus_a.REQ_READY), 32'd0);
    @(negedge CLK);
    bus_a.REQ_VALID = '0;
    #1;
    check("busy_ready_send2", 32'(bus_a.REQ_READY), 32'd0);
    check("busy_hold", 32'(bus_a.PAR_IN), 32'hA);
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    check("busy_no_extra_fs", 32'(bus_a.FRAME_START), 32'd0);
    check("busy_no_extra_act", 32'(bus_a.SER_ACTIVE), 32'd0);
    bus_a.REQ_VALID = 4'b0100;
    #1;
    check("busy_then_ready2", 32'(bus_a.REQ_READY), 32'b0100);
    push(0, 2, 32'hC);

    // Reset in the second SEND cycle of requester 2's frame.
    @(negedge CLK);
    bus_a.REQ_VALID = '0;
    snap(0, fs, act, par, gid, rdy);
    e = sb_a.pop_front();
    check("abort_fs", 32'(fs), 32'd1);
    check("abort_gid", gid, e.gid);
    check("abort_word", par, e.word);
    @(negedge CLK);
    check("abort_send2_word", 32'(bus_a.PAR_IN), 32'hC);
    RESET = 1'b1;
    bus_a.REQ_VALID = 4'b1100;
    #1;
    check("abort_ready_rst", 32'(bus_a.REQ_READY), 32'd0);
    @(negedge CLK);
    snap(0, fs, act, par, gid, rdy);
    check("abort_par", par, 32'd0);
    check("abort_active", 32'(act), 32'd0);
    check("abort_fs_low", 32'(fs), 32'd0);
    check("abort_gid_clr", gid, 32'd0);
    RESET = 1'b0;
    #1;
    check("abort_ptr0_ready", 32'(bus_a.REQ_READY), 32'b0100);
    push(0, 2, 32'hC);
    @(negedge CLK);
    bus_a.REQ_VALID = '0;
    check_frame(0, 2, 2, 0);
    @(negedge CLK);
    check("abort_no_reoffer", 32'(bus_a.FRAME_START), 32'd0);

    // GAP_CYCLES=0, INPUTS_NUM=8 instance: 4 SEND cycles + 1 IDLE cycle.
    bus_b.REQ_DATA[7:0] = 8'h5A;
    bus_b.REQ_VALID = 4'b0001;
    #1;
    check("b_ready", 32'(bus_b.REQ_READY), 32'b0001);
    push(1, 0, 32'h5A);
    check_frame(1, 4, 0, 0);
    @(negedge CLK);
    check("b_idle_par", 32'(bus_b.PAR_IN), 32'd0);
    check("b_idle_active", 32'(bus_b.SER_ACTIVE), 32'd0);
    check("b_idle_ready", 32'(bus_b.REQ_READY), 32'b0001);
    bus_b.REQ_DATA[7:0] = 8'hC3;
    push(1, 0, 32'hC3);
    check_frame(1, 4, 0, 5);
    @(negedge CLK);
    bus_b.REQ_DATA[7:0] = 8'h3C;
    push(1, 0, 32'h3C);
    check_frame(1, 4, 0, 5);
    bus_b.REQ_VALID = '0;
    @(negedge CLK);
    @(negedge CLK);
    check("b_stop_fs", 32'(bus_b.FRAME_START), 32'd0);
    check("b_stop_par", 32'(bus_b.PAR_IN), 32'd0);

    check("sb_a_drained", 32'(sb_a.size()), 32'd0);
    check("sb_b_drained", 32'(sb_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_tree_ser_arbiter.md
CONV_TREE_SER_ARBITER -- requirements
Module: conv_tree_ser_arbiter

Interface
REQ-001: Parameter INPUTS_NUM, default 4, serializer word width; power of two, >=4.
REQ-002: Parameter NUM_REQ, default 4, number of requesters, >=2.
REQ-003: Parameter GAP_CYCLES, default 2, idle (all-zero) cycles driven after each frame, >=0.
REQ-004: Derived SER_CYCLES = INPUTS_NUM/2, cycles a word is held on PAR_IN; IDW = $clog2(NUM_REQ).
REQ-005: CLK  input  1  single clock; all state changes on rising edge.
REQ-006: RESET  input  1  synchronous, active-high reset.
REQ-007: REQ_VALID  input  NUM_REQ  per-requester word-valid.
REQ-008: REQ_DATA  input  NUM_REQ*INPUTS_NUM  requester i word at [i*INPUTS_NUM +: INPUTS_NUM].
REQ-009: REQ_READY  output  NUM_REQ  one-hot grant/accept, combinational.
REQ-010: PAR_IN  output  INPUTS_NUM  registered word to serializer PAR_IN.
REQ-011: SER_ACTIVE  output  1  registered; high while a word is held on PAR_IN.
REQ-012: FRAME_START  output  1  registered; one-cycle pulse in first cycle of each frame.
REQ-013: GRANT_ID  output  IDW  registered index of requester owning current/last frame.

Function
REQ-014: FSM states IDLE, SEND, GAP; one down-counter shared by SEND and GAP.
REQ-015: IDLE, any REQ_VALID high: round-robin winner g = first valid index at or after pointer PTR, wrapping NUM_REQ-1 -> 0.
REQ-016: REQ_READY[g]=1 only in IDLE, only for winner, only when RESET low; all bits 0 otherwise.
REQ-017: Handshake = REQ_VALID[g] & REQ_READY[g]; on that edge: PAR_IN <= REQ_DATA word g, GRANT_ID <= g, PTR <= (g+1) mod NUM_REQ, counter <= SER_CYCLES-1, state -> SEND.
REQ-018: FRAME_START and SER_ACTIVE go high in the first SEND cycle; FRAME_START low after one cycle.
REQ-019: SEND: PAR_IN held constant, counter decrements each cycle; exactly SER_CYCLES SEND cycles.
REQ-020: SEND with counter==0: PAR_IN <= 0, SER_ACTIVE <= 0; GAP_CYCLES>0 -> GAP with counter <= GAP_CYCLES-1; GAP_CYCLES==0 -> IDLE.
REQ-021: GAP: PAR_IN stays 0, counter decrements; counter==0 -> IDLE; exactly GAP_CYCLES GAP cycles.
REQ-022: IDLE: PAR_IN = 0, SER_ACTIVE = 0; no handshake -> state, PTR, GRANT_ID unchanged.
REQ-023: Minimum frame period (handshake to handshake) = SER_CYCLES + GAP_CYCLES + 1 cycles.
REQ-024: REQ_VALID/REQ_DATA ignored outside IDLE; valid withdrawn before grant is not a handshake; data sampled only on handshake edge.
REQ-025: Single persistent requester is regranted every frame; PTR still advances past it.

Reset
REQ-026: RESET high at a rising edge: state IDLE, PAR_IN 0, SER_ACTIVE 0, FRAME_START 0, GRANT_ID 0, PTR 0, counter 0.
REQ-027: RESET during SEND/GAP aborts the frame; in-flight word discarded, not re-offered; REQ_READY 0 while RESET high.
REQ-028: First handshake possible in the first IDLE cycle with RESET low.

Verification (INPUTS_NUM=4, NUM_REQ=4, GAP_CYCLES=2 unless stated)
REQ-029: RESET 2 cycles, REQ_VALID=4'b1111 -> REQ_READY 0 throughout; all outputs 0 after first edge.
REQ-030: REQ_VALID=4'b0010, word1=4'b1011 -> REQ_READY=4'b0010 same cycle; next 2 cycles PAR_IN=4'b1011, SER_ACTIVE=1, FRAME_START=1 first cycle only, GRANT_ID=1; then 2 cycles PAR_IN=0; IDLE.
REQ-031: REQ_VALID=4'b1111 held, words 4'hA,4'h5,4'hC,4'h3 -> GRANT_ID 0,1,2,3,0; FRAME_START every 5 cycles; PAR_IN A,5,C,3,A.
REQ-032: Frame 0 in SEND, REQ_VALID changes 4'b0001 -> 4'b0100 -> 4'b0000 before IDLE -> no extra grant, REQ_READY 0 until IDLE, then only valid requesters granted.
REQ-033: RESET pulsed in 2nd SEND cycle of req 2 frame -> next edge PAR_IN=0, SER_ACTIVE=0, PTR=0; REQ_VALID=4'b1100 then grants requester 2.
REQ-034: GAP_CYCLES=0, INPUTS_NUM=8, REQ_VALID=4'b0001 held -> PAR_IN word for 4 cycles, 0 for 1 IDLE cycle, FRAME_START every 5 cycles.
